// File: rtl/ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_capture
// Brief    : Synchronises and de-glitches a free-running asynchronous ripple
//            counter, accumulates its modulo deltas into a wide count and
//            presents that count on a valid/ready interface with threshold
//            match and sticky overflow status.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_count_capture #(
   parameter int IN_W          = 4,
   parameter int EXT_W         = 16,
   parameter int STABLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  ripple_count,
   input  logic             clear,
   input  logic [EXT_W-1:0] threshold,
   output logic [EXT_W-1:0] ext_count,
   output logic             ext_valid,
   input  logic             ext_ready,
   output logic             match_pulse,
   output logic             overflow
);

   localparam int                 c_SW     = $clog2(STABLE_CYCLES + 1);
   localparam logic [c_SW-1:0]    c_STABLE = c_SW'(STABLE_CYCLES);
   localparam int                 c_PAD    = EXT_W + 1 - IN_W;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [IN_W-1:0]   r_sync1;
   logic [IN_W-1:0]   r_sync2;
   logic [IN_W-1:0]   r_sync2_d;
   logic [c_SW-1:0]   r_stab_cnt;
   logic [IN_W-1:0]   r_baseline;
   logic [EXT_W-1:0]  r_acc;
   logic [EXT_W-1:0]  r_ext_count;
   logic              r_ext_valid;
   logic              r_match;
   logic              r_overflow;

   logic              w_settled;
   logic [IN_W-1:0]   w_sval;
   logic [IN_W-1:0]   w_delta;
   logic [EXT_W:0]    w_sum;
   logic              w_base_load;
   logic              w_accum;
   logic              w_hit;

   // Plain two-flop synchroniser; the filter below rejects multi-bit skew.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ripple_count;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync2_d  <= '0;
         r_stab_cnt <= '0;
      end else begin
         r_sync2_d <= r_sync2;
         if (r_sync2 != r_sync2_d) begin
            r_stab_cnt <= c_SW'(1);
         end else if (r_stab_cnt != c_STABLE) begin
            r_stab_cnt <= r_stab_cnt + c_SW'(1);
         end
      end
   end

   // The equality term stops a freshly changed sample riding on an old count.
   assign w_settled = (r_stab_cnt == c_STABLE) && (r_sync2 == r_sync2_d);
   assign w_sval    = r_sync2;
   assign w_delta   = w_sval - r_baseline;
   assign w_sum     = {1'b0, r_acc} + {{c_PAD{1'b0}}, w_delta};
   assign w_hit     = (r_acc < threshold) && (threshold <= w_sum[EXT_W-1:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_base_load = 1'b0;
      w_accum     = 1'b0;
      if (clear) begin
         w_state_nxt = ST_INIT;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (w_settled) begin
                  w_base_load = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_settled && (w_sval != r_baseline)) begin
                  w_base_load = 1'b1;
                  w_accum     = 1'b1;
               end
            end
            default: w_state_nxt = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_baseline <= '0;
         r_acc      <= '0;
         r_overflow <= 1'b0;
         r_match    <= 1'b0;
      end else begin
         r_match <= w_accum && !w_sum[EXT_W] && w_hit;
         if (w_base_load) begin
            r_baseline <= w_sval;
         end
         if (clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
         end else if (w_accum) begin
            r_acc <= w_sum[EXT_W-1:0];
            if (w_sum[EXT_W]) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   // Output register only reloads when idle or consumed, so intermediate
   // accumulator values may be skipped while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ext_count <= '0;
         r_ext_valid <= 1'b0;
      end else if (clear) begin
         r_ext_valid <= 1'b0;
      end else if (!r_ext_valid || ext_ready) begin
         if (r_acc != r_ext_count) begin
            r_ext_count <= r_acc;
            r_ext_valid <= 1'b1;
         end else begin
            r_ext_valid <= 1'b0;
         end
      end
   end

   assign ext_count   = r_ext_count;
   assign ext_valid   = r_ext_valid;
   assign match_pulse = r_match;
   assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_count_capture
// Brief    : Directed self-checking bench for ripple_count_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_count_capture;

   logic        clk = 1'b0;
   int          errors = 0;
   int          checks = 0;

   logic        reset = 1'b1;
   logic [3:0]  ripple = 4'd0;
   logic        clear = 1'b0;
   logic [15:0] threshold = 16'hFFFF;
   logic [15:0] ext_count;
   logic        ext_valid;
   logic        ext_ready = 1'b1;
   logic        match_pulse;
   logic        overflow;

   logic        reset2 = 1'b1;
   logic [3:0]  ripple2 = 4'd0;
   logic        clear2 = 1'b0;
   logic [5:0]  threshold2 = 6'h3F;
   logic [5:0]  ext_count2;
   logic        ext_valid2;
   logic        ext_ready2 = 1'b1;
   logic        match_pulse2;
   logic        overflow2;

   always #5 clk = ~clk;

   ripple_count_capture #(.IN_W(4), .EXT_W(16), .STABLE_CYCLES(2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .ripple_count (ripple),
      .clear        (clear),
      .threshold    (threshold),
      .ext_count    (ext_count),
      .ext_valid    (ext_valid),
      .ext_ready    (ext_ready),
      .match_pulse  (match_pulse),
      .overflow     (overflow)
   );

   ripple_count_capture #(.IN_W(4), .EXT_W(6), .STABLE_CYCLES(2)) u_dut6 (
      .clk          (clk),
      .reset        (reset2),
      .ripple_count (ripple2),
      .clear        (clear2),
      .threshold    (threshold2),
      .ext_count    (ext_count2),
      .ext_valid    (ext_valid2),
      .ext_ready    (ext_ready2),
      .match_pulse  (match_pulse2),
      .overflow     (overflow2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tick(3);
      check("rst_count", ext_count, 0);
      check("rst_valid", ext_valid, 0);
      check("rst_match", match_pulse, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      tick(10);
      check("idle_valid", ext_valid, 0);

      // T1: latency and single-cycle presentation with ready high
      ripple = 4'd1;
      tick(5);
      check("t1_lat_early", ext_valid, 0);
      tick(1);
      check("t1_lat_valid", ext_valid, 1);
      check("t1_cnt1", ext_count, 1);
      tick(1);
      check("t1_one_cycle", ext_valid, 0);
      tick(5);
      ripple = 4'd2;
      tick(6);
      check("t1_cnt2", ext_count, 2);
      check("t1_valid2", ext_valid, 1);
      tick(1);
      check("t1_drop2", ext_valid, 0);
      tick(5);
      ext_ready = 1'b0;
      ripple = 4'd3;
      tick(6);
      check("t1_cnt3", ext_count, 3);
      check("t1_valid3", ext_valid, 1);

      // T2: stall holds presented value while accumulator moves on
      ripple = 4'd7;
      tick(10);
      check("t2_hold_cnt", ext_count, 3);
      check("t2_hold_valid", ext_valid, 1);
      ext_ready = 1'b1;
      tick(1);
      check("t2_next_cnt", ext_count, 7);
      check("t2_next_valid", ext_valid, 1);
      tick(1);
      check("t2_consumed", ext_valid, 0);

      // T3: modulo wrap of the input counter
      ripple = 4'd14;
      tick(8);
      check("t3_cnt14", ext_count, 14);
      ripple = 4'd2;
      tick(8);
      check("t3_wrap_cnt", ext_count, 18);
      check("t3_no_ovf", overflow, 0);

      // T4: one-cycle glitch through 0000 must be ignored
      ripple = 4'd7;
      tick(8);
      check("t4_cnt23", ext_count, 23);
      ripple = 4'd0;
      tick(1);
      ripple = 4'd8;
      tick(10);
      check("t4_glitch", ext_count, 24);

      // T5: threshold crossing and clear behaviour
      threshold = 16'd5;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("t5_clr_valid", ext_valid, 0);
      tick(1);
      check("t5_clr_cnt", ext_count, 0);
      tick(8);
      ripple = 4'd11;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("t5_nomatch", match_pulse, 0);
      end
      check("t5_cnt3", ext_count, 3);
      ext_ready = 1'b0;
      ripple = 4'd14;
      tick(4);
      check("t5_match_pre", match_pulse, 0);
      tick(1);
      check("t5_match", match_pulse, 1);
      tick(1);
      check("t5_match_post", match_pulse, 0);
      check("t5_cnt6", ext_count, 6);
      check("t5_valid6", ext_valid, 1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("t5_clr2_valid", ext_valid, 0);
      check("t5_clr2_hold", ext_count, 6);
      tick(1);
      check("t5_zero_cnt", ext_count, 0);
      check("t5_zero_valid", ext_valid, 1);
      ext_ready = 1'b1;
      tick(10);
      check("t5_rebase_cnt", ext_count, 0);
      check("t5_rebase_valid", ext_valid, 0);

      // T6: narrow accumulator wraps and flags sticky overflow
      reset2 = 1'b0;
      tick(10);
      ripple2 = 4'd15; tick(8);
      ripple2 = 4'd14; tick(8);
      ripple2 = 4'd13; tick(8);
      ripple2 = 4'd12; tick(8);
      check("t6_cnt60", ext_count2, 60);
      ripple2 = 4'd14; tick(8);
      check("t6_cnt62", ext_count2, 62);
      check("t6_ovf0", overflow2, 0);
      ripple2 = 4'd2; tick(8);
      check("t6_wrap_cnt", ext_count2, 2);
      check("t6_ovf1", overflow2, 1);
      check("t6_wrap_nomatch", match_pulse2, 0);
      ripple2 = 4'd3; tick(8);
      check("t6_cnt3", ext_count2, 3);
      check("t6_sticky", overflow2, 1);
      ext_ready2 = 1'b0;
      ripple2 = 4'd5; tick(8);
      check("t6_pend_cnt", ext_count2, 5);
      check("t6_pend_valid", ext_valid2, 1);
      #2;
      reset2 = 1'b1;
      #1;
      check("t6_rst_cnt", ext_count2, 0);
      check("t6_rst_valid", ext_valid2, 0);
      check("t6_rst_ovf", overflow2, 0);
      check("t6_rst_match", match_pulse2, 0);
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
